// File: rtl/shared_alu_arbiter_if.sv
// Opcode package and bus interface for the shared ALU arbiter.
// SHARED_ALU_STATS_EN adds the per-core completion and wait counters to the bus.
package shared_alu_pkg;
  typedef enum logic [2:0] {
    clr_alu = 3'd0,
    add_alu = 3'd1,
    sub_alu = 3'd2,
    mul_alu = 3'd3,
    inc_alu = 3'd4,
    and_alu = 3'd5,
    or_alu  = 3'd6,
    xor_alu = 3'd7
  } alu_op_t;
endpackage

interface shared_alu_arbiter_if #(
  parameter int WIDTH = 12,
  parameter int N_REQ = 4
);
  import shared_alu_pkg::*;

  logic [N_REQ-1:0] req;
  alu_op_t          op_in [N_REQ];
  logic [WIDTH-1:0] a_in  [N_REQ];
  logic [WIDTH-1:0] b_in  [N_REQ];
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  alu_op_t          alu_op;
  logic [WIDTH-1:0] alu_c;
  logic             busy;
`ifdef SHARED_ALU_STATS_EN
  logic [15:0]      grant_cnt [N_REQ];
  logic [15:0]      wait_cycles;

  modport slave (
    input  req, op_in, a_in, b_in, alu_c,
    output grant, done, result, alu_a, alu_b, alu_op, busy, grant_cnt, wait_cycles
  );
  modport master (
    output req, op_in, a_in, b_in, alu_c,
    input  grant, done, result, alu_a, alu_b, alu_op, busy, grant_cnt, wait_cycles
  );
`else
  modport slave (
    input  req, op_in, a_in, b_in, alu_c,
    output grant, done, result, alu_a, alu_b, alu_op, busy
  );
  modport master (
    output req, op_in, a_in, b_in, alu_c,
    input  grant, done, result, alu_a, alu_b, alu_op, busy
  );
`endif
endinterface

// File: rtl/shared_alu_arbiter.sv
// Round-robin arbiter time-sharing one combinational ALU between N_REQ cores.
// Optional SHARED_ALU_STATS_EN adds grant_cnt / wait_cycles counters.
//
// state | meaning
// IDLE  | waiting for a request; winner latched on the exit edge
// EXEC  | operands frozen on the ALU, cnt counts down the op latency
// RESP  | done pulses for the owner, grant still high
module shared_alu_arbiter
  import shared_alu_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int N_REQ      = 4,
  parameter int MUL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  shared_alu_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] grant_r;
  logic [N_REQ-1:0] done_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  alu_op_t          alu_op_r;
  logic             busy_c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // First requester at or above rr_ptr, wrapping around
  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    jj         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IDX_W'(j);
      if (!pick_valid && bus.req[jj]) begin
        pick_valid = 1'b1;
        pick_idx   = jj;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      cnt      <= '0;
      grant_r  <= '0;
      done_r   <= '0;
      result_r <= '0;
      alu_a_r  <= '0;
      alu_b_r  <= '0;
      alu_op_r <= clr_alu;
    end else begin
      done_r <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            alu_op_r <= bus.op_in[pick_idx];
            alu_a_r  <= bus.a_in[pick_idx];
            alu_b_r  <= bus.b_in[pick_idx];
            grant_r  <= N_REQ'(1) << pick_idx;
            owner    <= pick_idx;
            cnt      <= (bus.op_in[pick_idx] == mul_alu) ? CNT_W'(MUL_CYCLES - 1) : '0;
          end else begin
            alu_op_r <= clr_alu;
            grant_r  <= '0;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            result_r <= bus.alu_c;
            done_r   <= grant_r;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          grant_r <= '0;
          rr_ptr  <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_c = (state != IDLE);
  end

  assign bus.grant  = grant_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.alu_a  = alu_a_r;
  assign bus.alu_b  = alu_b_r;
  assign bus.alu_op = alu_op_r;
  assign bus.busy   = busy_c;

`ifdef SHARED_ALU_STATS_EN
  logic [15:0] grant_cnt_r [N_REQ];
  logic [15:0] wait_r;

  // Idle cycles count toward wait_cycles too: grant is 0 there
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt_r[i] <= '0;
      wait_r <= '0;
    end else begin
      if (state == RESP && grant_cnt_r[owner] != 16'hFFFF)
        grant_cnt_r[owner] <= grant_cnt_r[owner] + 16'd1;
      if ((bus.req & ~grant_r) != '0 && wait_r != 16'hFFFF)
        wait_r <= wait_r + 16'd1;
    end
  end

  assign bus.grant_cnt   = grant_cnt_r;
  assign bus.wait_cycles = wait_r;
`endif

endmodule

// File: tb/tb_shared_alu_arbiter.sv
// Self-checking bench for shared_alu_arbiter: transaction-timeline model plus
// directed scenarios with hand-computed results.
module tb_shared_alu_arbiter;
  import shared_alu_pkg::*;

  localparam int WIDTH      = 12;
  localparam int N_REQ      = 4;
  localparam int MUL_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  shared_alu_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  shared_alu_arbiter #(
    .WIDTH(WIDTH), .N_REQ(N_REQ), .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [WIDTH-1:0] alu_fn(alu_op_t op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = $signed(a) * $signed(b);
    case (op)
      add_alu: return a + b;
      sub_alu: return a - b;
      mul_alu: return p[WIDTH-1:0];
      inc_alu: return a + 1'b1;
      and_alu: return a & b;
      or_alu:  return a | b;
      xor_alu: return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_c = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted request occupies the cycles [g_lo, g_hi] with grant,
  // done on g_hi, and the next arbitration edge is free_at.
  int               cyc = 0;
  int               free_at = 0;
  int               g_lo = -100;
  int               g_hi = -100;
  int               owner = 0;
  int               ptr = 0;
  bit               m_valid = 1'b0;
  logic [WIDTH-1:0] m_res, m_pend, m_a, m_b;
  alu_op_t          m_op;
  int               m_gcnt [N_REQ];
  int               m_wait;

  function automatic logic [N_REQ-1:0] exp_grant(int c);
    if (c >= g_lo && c <= g_hi) return N_REQ'(1) << owner;
    return '0;
  endfunction

  always @(posedge clk) begin : model_p
    logic [N_REQ-1:0] g_old;
    int w, l;
    g_old = exp_grant(cyc);
    cyc = cyc + 1;
    if (rst) begin
      m_valid = 1'b1;
      ptr = 0; g_lo = -100; g_hi = -100; free_at = cyc + 1;
      m_res = '0; m_a = '0; m_b = '0; m_op = clr_alu;
      for (int i = 0; i < N_REQ; i++) m_gcnt[i] = 0;
      m_wait = 0;
    end else if (m_valid) begin
      if ((bus.req & ~g_old) != '0 && m_wait < 65535) m_wait++;
      if (cyc == g_hi + 1 && m_gcnt[owner] < 65535) m_gcnt[owner]++;
      if (cyc == g_hi) m_res = m_pend;
      if (cyc >= free_at) begin
        if (bus.req != '0) begin
          w = -1;
          for (int k = 0; k < N_REQ; k++)
            if (w < 0 && bus.req[(ptr + k) % N_REQ]) w = (ptr + k) % N_REQ;
          owner  = w;
          m_op   = bus.op_in[w];
          m_a    = bus.a_in[w];
          m_b    = bus.b_in[w];
          m_pend = alu_fn(m_op, m_a, m_b);
          l      = (m_op == mul_alu) ? MUL_CYCLES : 1;
          g_lo   = cyc;
          g_hi   = cyc + l;
          free_at = cyc + l + 2;
          ptr    = (w + 1) % N_REQ;
        end else begin
          m_op = clr_alu;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("grant",  bus.grant,  exp_grant(cyc));
      check("done",   bus.done,   (cyc == g_hi) ? (N_REQ'(1) << owner) : N_REQ'(0));
      check("busy",   bus.busy,   exp_grant(cyc) != '0);
      check("result", bus.result, m_res);
      check("alu_op", 32'(bus.alu_op), 32'(m_op));
      check("alu_a",  bus.alu_a,  m_a);
      check("alu_b",  bus.alu_b,  m_b);
`ifdef SHARED_ALU_STATS_EN
      for (int i = 0; i < N_REQ; i++) check("grant_cnt", bus.grant_cnt[i], m_gcnt[i]);
      check("wait_cycles", bus.wait_cycles, m_wait);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n, output logic [N_REQ-1:0] d);
    n = 0;
    d = '0;
    while (n < 12 && d == '0) begin
      tick();
      n++;
      d = bus.done;
    end
  endtask

  // One request from core idx; checks grant after first edge, latency and result.
  task automatic run_op(input int idx, input alu_op_t op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_res, input int lat);
    int n;
    logic [N_REQ-1:0] d;
    bus.op_in[idx] = op;
    bus.a_in[idx]  = a;
    bus.b_in[idx]  = b;
    bus.req[idx]   = 1'b1;
    tick();
    check("op_grant", bus.grant, N_REQ'(1) << idx);
    n = 1;
    d = bus.done;
    while (n < 12 && d == '0) begin
      tick();
      n++;
      d = bus.done;
    end
    check("op_latency", n, lat + 1);
    check("op_done", d, N_REQ'(1) << idx);
    check("op_result", bus.result, exp_res);
    bus.req[idx] = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int ord [5];
    int rcy [5];
    logic [WIDTH-1:0] rres [5];
    int exp_ord [5];
    logic [WIDTH-1:0] exp_r [5];
    int nrec, n;
    logic [N_REQ-1:0] d;

    exp_ord = '{0, 1, 2, 3, 0};
    exp_r   = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd1};
    bus.req = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.op_in[i] = add_alu;
      bus.a_in[i]  = '0;
      bus.b_in[i]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_grant", bus.grant, 0);
    check("reset_alu_op", 32'(bus.alu_op), 32'(clr_alu));

    // 1: simple add
    run_op(0, add_alu, 12'd5, 12'd7, 12'd12, 1);

    // 2: all cores requesting, rotation from core 0
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      bus.op_in[i] = inc_alu;
      bus.a_in[i]  = WIDTH'(i);
    end
    bus.req = '1;
    nrec = 0;
    for (int c = 0; c < 25 && nrec < 5; c++) begin
      tick();
      if (bus.done != '0) begin
        for (int i = 0; i < N_REQ; i++) if (bus.done[i]) ord[nrec] = i;
        rres[nrec] = bus.result;
        rcy[nrec]  = c;
        nrec++;
      end
    end
    bus.req = '0;
    check("rr_count", nrec, 5);
    for (int i = 0; i < nrec; i++) begin
      check("rr_order", ord[i], exp_ord[i]);
      check("rr_result", rres[i], exp_r[i]);
      if (i > 0) check("rr_spacing", rcy[i] - rcy[i-1], 3);
    end
    tick();

    // 3: signed multiply, 2 EXEC cycles
    run_op(2, mul_alu, 12'hFFD, 12'd4, 12'hFF4, MUL_CYCLES);

    // 4: overflow wrap cases
    run_op(3, mul_alu, 12'h040, 12'h040, 12'h000, MUL_CYCLES);
    run_op(1, add_alu, 12'h7FF, 12'h001, 12'h800, 1);
    run_op(1, sub_alu, 12'h000, 12'h001, 12'hFFF, 1);

    // 5: reset during mul EXEC, then pointer restarts at core 0
    bus.op_in[2] = mul_alu;
    bus.a_in[2]  = 12'd3;
    bus.b_in[2]  = 12'd3;
    bus.req      = 4'b0100;
    tick();
    check("t5_grant", bus.grant, 4'b0100);
    rst = 1'b1;
    bus.req = '0;
    tick();
    check("t5_rst_grant", bus.grant, 0);
    check("t5_rst_done", bus.done, 0);
    check("t5_rst_result", bus.result, 0);
    check("t5_rst_busy", bus.busy, 0);
    rst = 1'b0;
    bus.op_in[0] = add_alu; bus.a_in[0] = 12'd1; bus.b_in[0] = 12'd1;
    bus.op_in[3] = add_alu; bus.a_in[3] = 12'd2; bus.b_in[3] = 12'd2;
    bus.req = 4'b1001;
    wait_done(n, d);
    check("t5_first_lat", n, 2);
    check("t5_first_done", d, 4'b0001);
    check("t5_first_result", bus.result, 12'd2);
    bus.req[0] = 1'b0;
    wait_done(n, d);
    check("t5_second_lat", n, 3);
    check("t5_second_done", d, 4'b1000);
    check("t5_second_result", bus.result, 12'd4);
    bus.req[3] = 1'b0;
    tick();

    // 6: late request from core 1 withdrawn during core 3's EXEC; core 3 drops
    //    req and changes operands mid-EXEC, which must not matter
    bus.op_in[3] = mul_alu; bus.a_in[3] = 12'd5; bus.b_in[3] = 12'd6;
    bus.req = 4'b1000;
    tick();
    check("t6_grant", bus.grant, 4'b1000);
    bus.op_in[1] = add_alu;
    bus.req = 4'b0010;
    bus.a_in[3] = 12'd100;
    tick();
    check("t6_no_grant1", bus.grant[1], 1'b0);
    bus.req = '0;
    tick();
    check("t6_done", bus.done, 4'b1000);
    check("t6_result", bus.result, 12'h01E);
    tick();
    tick();
    check("t6_idle_grant", bus.grant, 0);
    check("t6_idle_busy", bus.busy, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
